dir_cmd_decoder: RTL
====================

// Module: dir_cmd_decoder
// PURPOSE
//   Receiving end of the 3-bit button/direction code produced by encoder7to3.
//   Filters the code, turns presses into single commands with auto-repeat for
//   movement keys, and holds each command in a valid/ready output register.
//   Sits between encoder7to3 and state_transition so the game FSM runs on clk
//   and takes exactly one command per press or repeat.
// PARAMETERS
//   STABLE_TICKS  3   consecutive equal tick samples that qualify a code (>=1)
//   REPEAT_DELAY  8   ticks a movement code is held before the first repeat
//   REPEAT_RATE   2   ticks between later repeats
//   CNT_W         4   tick-counter width; must hold max(STABLE_TICKS,REPEAT_DELAY)
// PORTS
//   clk            in   1  system clock
//   reset_n        in   1  asynchronous active-low reset
//   tick_en        in   1  one-clk-wide sample strobe (8 Hz rate)
//   dir_in         in   3  encoded button code (see package constants)
//   cmd_ready      in   1  consumer accepts cmd this clk when cmd_valid=1
//   cmd_valid      out  1  command pending
//   cmd_code       out  3  pending command code, never DIR_NONE while valid
//   cmd_move       out  4  one-hot {up,down,left,right}, gated by cmd_valid
//   cmd_score_rst  out  2  {red,blue} reset request, gated by cmd_valid
//   overrun        out  1  sticky: a command was dropped
// BEHAVIOUR
//   Codes: 0 NONE, 1 RIGHT, 2 LEFT, 3 DOWN, 4 UP, 5 DECIDE, 6 RST_RED, 7 RST_BLUE.
//   Reset (async, any time): all outputs 0, FSM IDLE, counters 0, pending cmd
//     discarded. Reset mid-press: the press is ignored until released and
//     pressed again. Sampling resumes on the first tick_en after release.
//   dir_in is registered only on tick_en. All FSM moves happen on tick_en clks.
//   FSM states:
//     IDLE    : sample!=NONE -> QUALIFY, cnt=1, cand=sample.
//     QUALIFY : sample==cand -> cnt++; at cnt==STABLE_TICKS issue cand, go HELD,
//               cnt=0. sample!=cand -> IDLE (NONE) or restart QUALIFY (new cand).
//     HELD    : sample==cand -> cnt++; movement code (1-4) and cnt==REPEAT_DELAY
//               -> issue, REPEAT, cnt=0. DECIDE and resets never repeat.
//               sample!=cand -> IDLE (no cmd on release).
//     REPEAT  : sample==cand -> cnt++; cnt==REPEAT_RATE -> issue, cnt=0.
//               sample!=cand -> IDLE.
//   STABLE_TICKS==1: the qualifying sample issues on the same tick as IDLE exit.
//   Issue latency: cmd_valid rises the clk after the qualifying tick_en clk.
//   Handshake: cmd_valid/cmd_code stay stable until cmd_valid&&cmd_ready.
//     cmd_valid falls the clk after acceptance unless a new issue happens in
//     that same clk (back-to-back allowed: new cmd loads, valid stays 1).
//   Issue while pending and not accepted in that clk:
//     new code RST_RED/RST_BLUE -> replaces pending cmd, overrun=1.
//     otherwise -> new cmd dropped, overrun=1.
//   overrun clears only on reset.
//   cmd_move/cmd_score_rst are decodes of cmd_code ANDed with cmd_valid.
//   Counters saturate, never wrap. tick_en at 0 -> no state change.
// STRUCTURE
//   Package game_pkg: DIR_* localparams (3-bit codes above), FSM state
//     encoding, is_move(code) function (also used by encoder7to3 and
//     state_transition).
//   One sub-module: cmd_out_reg (1-entry valid/ready holding register with
//     priority-replace and overrun flag). The filter FSM stays in the top.
// TESTING
//   1 Default params. Hold UP(4) 3 ticks, ready=1 -> one cmd_code=4,
//     cmd_move=4'b1000, 1 clk valid. No second cmd before tick 11.
//   2 Hold LEFT(2) 20 ticks -> cmds at ticks 3,11,13,15,17,19 (6 total).
//     Release -> no extra cmd.
//   3 Hold DECIDE(5) 20 ticks -> exactly one cmd. Glitch 5,5,3,5,5,5 -> one
//     cmd, issued on the 6th sample.
//   4 ready=0, issue RIGHT then DECIDE -> code stays 1, overrun=1. Then issue
//     RST_BLUE -> code becomes 7, cmd_score_rst=2'b01.
//   5 Pending cmd, then ready pulses on the same clk as a new issue -> valid
//     stays 1, code updates, overrun stays 0.
//   6 Assert reset_n=0 mid-REPEAT, between clk edges -> all outputs 0 at once.
//     Release with the key still held -> no cmd until release and re-press.

Source files
------------

// File: rtl/game_pkg.sv
// Shared button/direction codes, filter FSM encoding and code classifiers.
// Used by encoder7to3, dir_cmd_decoder and state_transition.
package game_pkg;

   localparam logic [2:0] DIR_NONE     = 3'd0;
   localparam logic [2:0] DIR_RIGHT    = 3'd1;
   localparam logic [2:0] DIR_LEFT     = 3'd2;
   localparam logic [2:0] DIR_DOWN     = 3'd3;
   localparam logic [2:0] DIR_UP       = 3'd4;
   localparam logic [2:0] DIR_DECIDE   = 3'd5;
   localparam logic [2:0] DIR_RST_RED  = 3'd6;
   localparam logic [2:0] DIR_RST_BLUE = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_QUALIFY = 2'd1,
      ST_HELD    = 2'd2,
      ST_REPEAT  = 2'd3
   } fsm_state_t;

   function automatic logic is_move(input logic [2:0] code);
      return (code >= DIR_RIGHT) && (code <= DIR_UP);
   endfunction

   function automatic logic is_score_rst(input logic [2:0] code);
      return (code == DIR_RST_RED) || (code == DIR_RST_BLUE);
   endfunction

endpackage

// File: rtl/cmd_out_reg.sv
// One-entry valid/ready command holder; loads the clk after issue, holds until accepted.
// Issue into a full, unaccepted slot drops the new cmd (score resets replace it) and sets sticky overrun.
module cmd_out_reg
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       issue,
   input  logic [2:0] issue_code,
   input  logic       ready,
   output logic       valid,
   output logic [2:0] code,
   output logic       overrun
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid   <= 1'b0;
         code    <= DIR_NONE;
         overrun <= 1'b0;
      end else if (issue) begin
         if (!valid || ready) begin
            valid <= 1'b1;
            code  <= issue_code;
         end else begin
            // Score resets outrank whatever is waiting; anything else is lost.
            overrun <= 1'b1;
            if (is_score_rst(issue_code)) begin
               code <= issue_code;
            end
         end
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dir_cmd_decoder.sv
// Debounces the 3-bit button code into one command per press/repeat; cmd_valid rises the clk after the qualifying tick.
// Commands wait in a 1-entry valid/ready register; issues while it is full are dropped (or replace, for score resets) and flag overrun.
module dir_cmd_decoder
   import game_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 3,
   parameter int unsigned REPEAT_DELAY = 8,
   parameter int unsigned REPEAT_RATE  = 2,
   parameter int unsigned CNT_W        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick_en,
   input  logic [2:0] dir_in,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   output logic [3:0] cmd_move,
   output logic [1:0] cmd_score_rst,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
   localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_C   = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   fsm_state_t       state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt, cnt_inc;
   logic [2:0]       cand, nxt_cand;
   logic             armed, nxt_armed;
   logic             issue;
   logic             same;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + ONE_C;
   assign same    = (dir_in == cand);

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_cand  = cand;
      nxt_armed = armed;
      issue     = 1'b0;
      if (tick_en) begin
         // After reset a key already down is ignored until it is seen released.
         if (!armed) begin
            if (dir_in == DIR_NONE) nxt_armed = 1'b1;
         end else begin
            case (state)
               ST_IDLE, ST_QUALIFY: begin
                  if (state == ST_QUALIFY && same) begin
                     nxt_cnt = cnt_inc;
                     if (cnt_inc == STABLE_C) begin
                        issue     = 1'b1;
                        nxt_state = ST_HELD;
                        nxt_cnt   = '0;
                     end
                  end else if (dir_in == DIR_NONE) begin
                     nxt_state = ST_IDLE;
                     nxt_cnt   = '0;
                  end else begin
                     nxt_cand = dir_in;
                     if (STABLE_C == ONE_C) begin
                        issue     = 1'b1;
                        nxt_state = ST_HELD;
                        nxt_cnt   = '0;
                     end else begin
                        nxt_state = ST_QUALIFY;
                        nxt_cnt   = ONE_C;
                     end
                  end
               end
               ST_HELD: begin
                  if (same) begin
                     nxt_cnt = cnt_inc;
                     if (is_move(cand) && cnt_inc == DELAY_C) begin
                        issue     = 1'b1;
                        nxt_state = ST_REPEAT;
                        nxt_cnt   = '0;
                     end
                  end else begin
                     nxt_state = ST_IDLE;
                     nxt_cnt   = '0;
                  end
               end
               ST_REPEAT: begin
                  if (same) begin
                     nxt_cnt = cnt_inc;
                     if (cnt_inc == RATE_C) begin
                        issue   = 1'b1;
                        nxt_cnt = '0;
                     end
                  end else begin
                     nxt_state = ST_IDLE;
                     nxt_cnt   = '0;
                  end
               end
               default: begin
                  nxt_state = ST_IDLE;
                  nxt_cnt   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         cand  <= DIR_NONE;
         armed <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         cand  <= nxt_cand;
         armed <= nxt_armed;
      end
   end

   cmd_out_reg u_cmd_out_reg (
      .clk        (clk),
      .reset_n    (reset_n),
      .issue      (issue),
      .issue_code (nxt_cand),
      .ready      (cmd_ready),
      .valid      (cmd_valid),
      .code       (cmd_code),
      .overrun    (overrun)
   );

   always_comb begin
      cmd_move      = 4'b0000;
      cmd_score_rst = 2'b00;
      if (cmd_valid) begin
         case (cmd_code)
            DIR_UP:       cmd_move      = 4'b1000;
            DIR_DOWN:     cmd_move      = 4'b0100;
            DIR_LEFT:     cmd_move      = 4'b0010;
            DIR_RIGHT:    cmd_move      = 4'b0001;
            DIR_RST_RED:  cmd_score_rst = 2'b10;
            DIR_RST_BLUE: cmd_score_rst = 2'b01;
            default:      ;
         endcase
      end
   end

endmodule
